// File: rtl/mac_lookup_table.sv
// 32-entry MAC table with sequential-scan DMAC lookup; first hit terminates the scan.
// Ack 1 cycle after accept (group), 2+k (hit at k), 33 (miss); requests while busy are dropped.
module mac_lookup_table #(
  parameter logic [8:0] FLOOD_MAP = 9'h1FF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [56:0] iv_smac_inport,
  input  logic [4:0]  iv_entry_addr,
  input  logic        i_mactable_wr,
  input  logic        i_table_clr,
  input  logic [47:0] iv_dmac,
  input  logic        i_lookup_req,
  output logic        o_lookup_busy,
  output logic        o_lookup_ack,
  output logic        o_lookup_hit,
  output logic [8:0]  ov_outport,
  output logic [15:0] ov_hit_cnt,
  output logic [15:0] ov_miss_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_valid;
  logic [47:0] r_mac [32];
  logic [8:0]  r_port [32];
  logic [47:0] r_key;
  logic [4:0]  r_idx;
  logic        r_hit;
  logic [8:0]  r_outport;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        w_match;
  logic        w_last;
  logic [31:0] w_wr_onehot;

  // Compare reads registered table contents, so a same-cycle write is seen only next cycle
  assign w_match     = r_valid[r_idx] && (r_mac[r_idx] == r_key);
  assign w_last      = (r_idx == 5'd31);
  assign w_wr_onehot = i_mactable_wr ? (32'd1 << iv_entry_addr) : 32'd0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_lookup_req) w_state_nxt = iv_dmac[40] ? RESP : SCAN;
      SCAN:    if (w_match || w_last) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_table_clr) begin
      r_valid <= w_wr_onehot;
    end else begin
      r_valid <= r_valid | w_wr_onehot;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_mactable_wr) begin
      r_mac[iv_entry_addr]  <= iv_smac_inport[56:9];
      r_port[iv_entry_addr] <= iv_smac_inport[8:0];
    end
  end

  // Result and counters load on the edge into RESP so they are valid alongside the ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_idx      <= '0;
      r_hit      <= 1'b0;
      r_outport  <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (i_lookup_req) begin
            r_key <= iv_dmac;
            r_idx <= '0;
            if (iv_dmac[40]) begin
              r_hit     <= 1'b0;
              r_outport <= FLOOD_MAP;
            end
          end
        end
        SCAN: begin
          if (w_match) begin
            r_hit     <= 1'b1;
            r_outport <= r_port[r_idx];
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else if (w_last) begin
            r_hit     <= 1'b0;
            r_outport <= FLOOD_MAP;
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_lookup_busy = (r_state != IDLE);
  assign o_lookup_ack  = (r_state == RESP);
  assign o_lookup_hit  = r_hit;
  assign ov_outport    = r_outport;
  assign ov_hit_cnt    = r_hit_cnt;
  assign ov_miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_mac_lookup_table.sv
// Randomized bench for mac_lookup_table against a table/scan reference model.
module tb_mac_lookup_table;

  localparam logic [8:0] FLOOD = 9'h1FF;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [56:0] iv_smac_inport = '0;
  logic [4:0]  iv_entry_addr = '0;
  logic        i_mactable_wr = 1'b0;
  logic        i_table_clr = 1'b0;
  logic [47:0] iv_dmac = '0;
  logic        i_lookup_req = 1'b0;
  logic        o_lookup_busy;
  logic        o_lookup_ack;
  logic        o_lookup_hit;
  logic [8:0]  ov_outport;
  logic [15:0] ov_hit_cnt;
  logic [15:0] ov_miss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit          m_valid [32];
  logic [47:0] m_mac   [32];
  logic [8:0]  m_port  [32];
  logic [15:0] m_hit_cnt  = 0;
  logic [15:0] m_miss_cnt = 0;

  mac_lookup_table #(.FLOOD_MAP(FLOOD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .iv_smac_inport(iv_smac_inport), .iv_entry_addr(iv_entry_addr),
    .i_mactable_wr(i_mactable_wr), .i_table_clr(i_table_clr),
    .iv_dmac(iv_dmac), .i_lookup_req(i_lookup_req),
    .o_lookup_busy(o_lookup_busy), .o_lookup_ack(o_lookup_ack),
    .o_lookup_hit(o_lookup_hit), .ov_outport(ov_outport),
    .ov_hit_cnt(ov_hit_cnt), .ov_miss_cnt(ov_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_hit_cnt  = 0;
    m_miss_cnt = 0;
  endfunction

  // Lowest valid matching index wins; latency counted in edges from the request cycle
  function automatic void model_lookup(input logic [47:0] d, output bit hit,
                                       output logic [8:0] port, output int lat);
    hit = 1'b0; port = FLOOD; lat = 33;
    if (d[40]) begin
      lat = 1;
      return;
    end
    for (int i = 0; i < 32; i++) begin
      if (m_valid[i] && m_mac[i] == d) begin
        hit = 1'b1; port = m_port[i]; lat = 2 + i;
        return;
      end
    end
  endfunction

  function automatic void model_count(input logic [47:0] d, input bit hit, input int n);
    for (int i = 0; i < n; i++) begin
      if (!d[40]) begin
        if (hit) m_hit_cnt  = (m_hit_cnt  == 16'hFFFF) ? 16'hFFFF : m_hit_cnt + 16'd1;
        else     m_miss_cnt = (m_miss_cnt == 16'hFFFF) ? 16'hFFFF : m_miss_cnt + 16'd1;
      end
    end
  endfunction

  function automatic logic [47:0] rand_ucast();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[40] = 1'b0;
    return r[47:0];
  endfunction

  task automatic wr_entry(input logic [4:0] a, input logic [47:0] mac,
                          input logic [8:0] p, input bit clr);
    @(posedge i_clk); #1;
    iv_entry_addr = a; iv_smac_inport = {mac, p}; i_mactable_wr = 1'b1; i_table_clr = clr;
    @(posedge i_clk); #1;
    i_mactable_wr = 1'b0; i_table_clr = 1'b0;
    if (clr) for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_valid[a] = 1'b1; m_mac[a] = mac; m_port[a] = p;
  endtask

  task automatic clr_table();
    @(posedge i_clk); #1; i_table_clr = 1'b1;
    @(posedge i_clk); #1; i_table_clr = 1'b0;
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
  endtask

  // Optional write of {d, wp} to entry wa while the scan is at lat == wr_at
  task automatic lookup(input logic [47:0] d, input string nm, input int wr_at,
                        input logic [4:0] wa, input logic [8:0] wp);
    bit e_hit; logic [8:0] e_port; int e_lat; int lat;
    model_lookup(d, e_hit, e_port, e_lat);
    model_count(d, e_hit, 1);
    @(posedge i_clk); #1;
    iv_dmac = d; i_lookup_req = 1'b1;
    iv_entry_addr = wa; iv_smac_inport = {d, wp};
    @(posedge i_clk); #1;
    i_lookup_req = 1'b0; lat = 1; i_mactable_wr = (wr_at == 1);
    while (!o_lookup_ack && lat < 40) begin
      @(posedge i_clk); #1;
      lat++;
      i_mactable_wr = (wr_at == lat);
    end
    i_mactable_wr = 1'b0;
    if (wr_at > 0 && wr_at <= lat) begin
      m_valid[wa] = 1'b1; m_mac[wa] = d; m_port[wa] = wp;
    end
    n_tests++;
    if (lat !== e_lat || o_lookup_ack !== 1'b1) begin
      n_fail++; $display("FAIL %s latency: got %0d ack=%b, expected %0d", nm, lat, o_lookup_ack, e_lat);
    end
    n_tests++;
    if (o_lookup_hit !== e_hit) begin
      n_fail++; $display("FAIL %s hit: got %b, expected %b", nm, o_lookup_hit, e_hit);
    end
    n_tests++;
    if (ov_outport !== e_port) begin
      n_fail++; $display("FAIL %s outport: got %h, expected %h", nm, ov_outport, e_port);
    end
    n_tests++;
    if (o_lookup_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_at_ack: got %b, expected 1", nm, o_lookup_busy);
    end
    n_tests++;
    if (ov_hit_cnt !== m_hit_cnt || ov_miss_cnt !== m_miss_cnt) begin
      n_fail++;
      $display("FAIL %s counters: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
               nm, ov_hit_cnt, ov_miss_cnt, m_hit_cnt, m_miss_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    n_tests++;
    if ({o_lookup_busy, o_lookup_ack, o_lookup_hit} !== 3'b000) begin
      n_fail++; $display("FAIL %s flags: got busy/ack/hit=%b, expected 000", nm,
                         {o_lookup_busy, o_lookup_ack, o_lookup_hit});
    end
    n_tests++;
    if (ov_outport !== 9'h000) begin
      n_fail++; $display("FAIL %s outport: got %h, expected 000", nm, ov_outport);
    end
    n_tests++;
    if (ov_hit_cnt !== 16'd0 || ov_miss_cnt !== 16'd0) begin
      n_fail++; $display("FAIL %s counters: got %0d/%0d, expected 0/0", nm, ov_hit_cnt, ov_miss_cnt);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    model_reset();
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
  endtask

  task automatic test_basic_hit();
    wr_entry(5'd0, 48'h0011_2233_4455, 9'h004, 1'b0);
    lookup(48'h0011_2233_4455, "hit_addr0", 0, 5'd0, 9'h0);
  endtask

  task automatic test_last_and_miss();
    clr_table();
    wr_entry(5'd31, 48'h0A0B_0C0D_0E0F, 9'h0A5, 1'b0);
    lookup(48'h0A0B_0C0D_0E0F, "hit_addr31", 0, 5'd0, 9'h0);
    lookup(rand_ucast(), "miss_absent", 0, 5'd0, 9'h0);
  endtask

  task automatic test_group();
    lookup(48'hFFFF_FFFF_FFFF, "bcast", 0, 5'd0, 9'h0);
    lookup(48'h0100_5E00_0001, "mcast", 0, 5'd0, 9'h0);
  endtask

  task automatic test_priority_and_overwrite();
    logic [47:0] mac;
    mac = rand_ucast();
    clr_table();
    wr_entry(5'd3, mac, 9'h002, 1'b0);
    wr_entry(5'd7, mac, 9'h080, 1'b0);
    lookup(mac, "lowest_index", 0, 5'd0, 9'h0);
    lookup(mac, "overwrite_during_compare", 4, 5'd3, 9'h011);
    lookup(mac, "after_overwrite", 0, 5'd0, 9'h0);
  endtask

  task automatic test_clear();
    logic [47:0] mac;
    logic [47:0] old_mac [32];
    int k;
    for (int i = 0; i < 32; i++) begin
      mac = rand_ucast();
      mac[4:0] = i[4:0];
      old_mac[i] = mac;
      wr_entry(i[4:0], mac, 9'($urandom), 1'b0);
    end
    for (int j = 0; j < 4; j++) begin
      k = $urandom_range(0, 31);
      lookup(old_mac[k], "rand_hit", 0, 5'd0, 9'h0);
    end
    mac = rand_ucast();
    mac[4:0] = 5'd5;
    mac[47] = ~old_mac[5][47];
    wr_entry(5'd5, mac, 9'h033, 1'b1);
    for (int j = 0; j < 3; j++) begin
      k = $urandom_range(0, 31);
      lookup(old_mac[k], "miss_after_clear", 0, 5'd0, 9'h0);
    end
    lookup(mac, "hit_after_clear_wr", 0, 5'd0, 9'h0);
  endtask

  task automatic test_back_to_back();
    bit e_hit; logic [8:0] e_port; int e_lat;
    int lat, acks, busy_lo;
    int t [3];
    t[0] = 0; t[1] = 0; t[2] = 0;
    model_lookup(m_mac[5], e_hit, e_port, e_lat);
    @(posedge i_clk); #1;
    iv_dmac = m_mac[5]; i_lookup_req = 1'b1;
    lat = 0; acks = 0; busy_lo = 0;
    while (acks < 3 && lat < 60) begin
      @(posedge i_clk); #1;
      lat++;
      if (o_lookup_ack) begin t[acks] = lat; acks++; end
      if (!o_lookup_busy && acks > 0) busy_lo++;
    end
    i_lookup_req = 1'b0;
    model_count(m_mac[5], e_hit, acks);
    n_tests++;
    if (acks !== 3 || t[0] !== e_lat) begin
      n_fail++; $display("FAIL b2b_first: got acks=%0d first=%0d, expected 3 and %0d", acks, t[0], e_lat);
    end
    n_tests++;
    if (t[1] - t[0] !== e_lat + 1 || t[2] - t[1] !== e_lat + 1) begin
      n_fail++; $display("FAIL b2b_period: got %0d,%0d, expected %0d", t[1] - t[0], t[2] - t[1], e_lat + 1);
    end
    n_tests++;
    if (busy_lo !== 2) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %0d idle cycles, expected 2", busy_lo);
    end
    n_tests++;
    if (ov_hit_cnt !== m_hit_cnt) begin
      n_fail++; $display("FAIL b2b_hit_cnt: got %0d, expected %0d", ov_hit_cnt, m_hit_cnt);
    end
  endtask

  task automatic test_saturate();
    @(posedge i_clk); #1;
    force dut.r_hit_cnt = 16'hFFFE;
    @(negedge i_clk);
    release dut.r_hit_cnt;
    m_hit_cnt = 16'hFFFE;
    lookup(m_mac[5], "hit_to_max", 0, 5'd0, 9'h0);
    lookup(m_mac[5], "hit_saturated", 0, 5'd0, 9'h0);
  endtask

  task automatic test_reset_mid_scan();
    logic [47:0] mac;
    int acks;
    mac = m_mac[5];
    @(posedge i_clk); #1;
    iv_dmac = mac; i_lookup_req = 1'b1;
    @(posedge i_clk); #1;
    i_lookup_req = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_mid_scan");
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_lookup_ack) acks++;
    end
    n_tests++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL reset_no_ack: got %0d acks, expected 0", acks);
    end
    lookup(mac, "miss_after_reset", 0, 5'd0, 9'h0);
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_last_and_miss();
    test_group();
    test_priority_and_overwrite();
    test_clear();
    test_back_to_back();
    test_saturate();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
